ofmap_deskew_buffer: RTL and testbench

- Sits directly downstream of the systolic MAC array.
- The array emits each output row diagonally: column c is valid c cycles after column 0. This block re-aligns those per-column results into one full-width output vector.
- Aligned vectors are buffered in a FIFO and presented on a valid/ready stream to the writeback/DMA stage.
- The array cannot be stalled, so any backpressure loss is reported, never hidden.

---
 rtl/ofmap_pkg.sv | 14 +
 rtl/sync_vec_fifo.sv | 83 ++++++++
 rtl/ofmap_deskew_buffer.sv | 129 ++++++++++++
 tb/tb_ofmap_deskew_buffer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_pkg.sv
// Shared types and default sizing for the output-feature-map datapath.
// Used by the deskew buffer and by the ifmap-side loader.
package ofmap_pkg;

    localparam int MAC_COL_DEF        = 16;
    localparam int OFMAP_BITWIDTH_DEF = 32;

    // One signed column result from the MAC array.
    typedef logic signed [OFMAP_BITWIDTH_DEF-1:0] ofmap_lane_t;

    // One full-width output row; lane c occupies bits [c*W +: W].
    typedef ofmap_lane_t [MAC_COL_DEF-1:0] ofmap_vec_t;

endpackage

// File: rtl/sync_vec_fifo.sv
// Generic synchronous valid/ready FIFO with an occupancy count.
// The read side is fully registered (no fall-through): rd_valid and rd_data
// always come straight from flops. A write into a full FIFO is accepted when
// the head is being read in the same cycle.
module sync_vec_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_next;
    logic             push;
    logic             pop;

    assign pop      = rd_valid && rd_ready;
    assign wr_ready = (count_q != CNT_W'(DEPTH)) || pop;
    assign push     = wr_valid && wr_ready;
    assign count    = count_q;

    // Next occupancy and the entry that becomes the head after this edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        head_next   = '0;
        remaining   = count_q - CNT_W'(pop);
        count_next  = remaining + CNT_W'(push);
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        if (count_next != '0) begin
            // When nothing older is left, the head is the word arriving now.
            if (remaining == '0) begin
                head_next = wr_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Pointers, count and the registered read port.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_next;
            count_q  <= count_next;
            rd_valid <= (count_next != '0);
            rd_data  <= head_next;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers and count alone decide which words are live.
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/ofmap_deskew_buffer.sv
// Re-aligns the diagonal per-column output of the systolic MAC array into
// full-width vectors, buffers them, and streams them out on valid/ready.
// The array cannot be stalled: vectors that do not fit are dropped and
// flagged (overflow_err), partially-valid stages are dropped and flagged
// (skew_err). Both flags are sticky until reset.
// Build option: define OFMAP_RELU_EN to clamp negative lanes to zero at
// the FIFO write; otherwise lanes pass through bit-exact.
module ofmap_deskew_buffer
    import ofmap_pkg::*;
#(
    parameter  int MAC_COL        = MAC_COL_DEF,
    parameter  int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF,
    parameter  int FIFO_DEPTH     = 8,
    parameter  int FRAME_LEN      = 1024,
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [MAC_COL-1:0]                           ofmap_valid_in,
    input  logic signed [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] ofmap_data_in,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0]            out_data,
    output logic [CNT_W-1:0]                             fifo_count,
    output logic                                         frame_done,
    output logic                                         overflow_err,
    output logic                                         skew_err
);

    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [MAC_COL-1:0]                     aligned_valid;
    logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] aligned_data;
    logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] wr_vec;
    logic                                   wr_candidate;
    logic                                   skew_hit;
    logic                                   fifo_wr_ready;
    logic [FC_W-1:0]                        frame_cnt;

    // Column c is delayed by MAC_COL-1-c cycles so all lanes of a row meet
    // at the aligned stage together; the last column is a plain wire.
    for (genvar c = 0; c < MAC_COL; c++) begin : g_lane
        localparam int LAT = MAC_COL - 1 - c;
        if (LAT == 0) begin : g_wire
            assign aligned_valid[c] = ofmap_valid_in[c];
            assign aligned_data[c]  = ofmap_data_in[c];
        end else begin : g_chain
            logic [LAT-1:0]                     v_q;
            logic [LAT-1:0][OFMAP_BITWIDTH-1:0] d_q;

            // Shift register carrying this column's valid and data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q[0] <= ofmap_valid_in[c];
                    d_q[0] <= ofmap_data_in[c];
                    for (int i = 1; i < LAT; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign aligned_valid[c] = v_q[LAT-1];
            assign aligned_data[c]  = d_q[LAT-1];
        end
    end

    // A stage is written only when every lane is present; a partial stage
    // means the array and this block disagree about the diagonal.
    assign wr_candidate = &aligned_valid;
    assign skew_hit     = (|aligned_valid) && !wr_candidate;

    // Data presented to the FIFO, optionally rectified.
    always_comb begin
        wr_vec = aligned_data;
`ifdef OFMAP_RELU_EN
        for (int c = 0; c < MAC_COL; c++) begin
            if (aligned_data[c][OFMAP_BITWIDTH-1]) begin
                wr_vec[c] = '0;
            end
        end
`endif
    end

    sync_vec_fifo #(
        .WIDTH (MAC_COL * OFMAP_BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_candidate),
        .wr_ready (fifo_wr_ready),
        .wr_data  (wr_vec),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .count    (fifo_count)
    );

    // Sticky error flags and the per-frame transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            skew_err     <= 1'b0;
            overflow_err <= 1'b0;
            frame_cnt    <= '0;
            frame_done   <= 1'b0;
        end else begin
            if (skew_hit) begin
                skew_err <= 1'b1;
            end
            if (wr_candidate && !fifo_wr_ready) begin
                overflow_err <= 1'b1;
            end
            frame_done <= 1'b0;
            if (out_valid && out_ready) begin
                if (frame_cnt == FC_W'(FRAME_LEN - 1)) begin
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ofmap_deskew_buffer.sv
// Self-checking bench for ofmap_deskew_buffer (FRAME_LEN shortened to 4).
// A queue-based reference model re-derives aligned vectors from the raw
// input history and is compared with the DUT every cycle; directed
// scenarios and a lane-value table cover the corner cases.
module tb_ofmap_deskew_buffer;
    import ofmap_pkg::*;

    localparam int MC = MAC_COL_DEF;
    localparam int W  = OFMAP_BITWIDTH_DEF;
    localparam int FD = 8;
    localparam int FL = 4;
    localparam int CW = $clog2(FD + 1);
    localparam int RING = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [MC-1:0]   vin;
    ofmap_vec_t      din;
    logic            out_valid;
    logic            out_ready;
    logic [MC*W-1:0] out_data;
    logic [CW-1:0]   fifo_count;
    logic            frame_done;
    logic            overflow_err;
    logic            skew_err;

    ofmap_deskew_buffer #(
        .MAC_COL        (MC),
        .OFMAP_BITWIDTH (W),
        .FIFO_DEPTH     (FD),
        .FRAME_LEN      (FL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ofmap_valid_in (vin),
        .ofmap_data_in  (din),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .fifo_count     (fifo_count),
        .frame_done     (frame_done),
        .overflow_err   (overflow_err),
        .skew_err       (skew_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_valid;

    // Scheduled per-cycle array output (diagonal injection ring).
    logic [MC-1:0] pv [RING];
    ofmap_vec_t    pd [RING];

    // Observations collected at the sampling point.
    ofmap_vec_t rx[$];
    int         xfer_cyc[$];
    int         fd_cyc[$];

    // Reference model state.
    logic [MC-1:0] hv[$];
    ofmap_vec_t    hd[$];
    ofmap_vec_t    mq[$];
    int            m_frame;
    bit            m_fd, m_ovf, m_skew;

    typedef struct {
        logic signed [W-1:0] val;
        logic signed [W-1:0] exp;
    } lane_case_t;

    task automatic check(input string name, input logic [MC*W-1:0] act, input logic [MC*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ofmap_vec_t relu_vec(input ofmap_vec_t v);
        relu_vec = v;
`ifdef OFMAP_RELU_EN
        for (int c = 0; c < MC; c++) begin
            if (v[c] < 0) relu_vec[c] = '0;
        end
`endif
    endfunction

    function automatic logic signed [W-1:0] relu_lane(input logic signed [W-1:0] v);
`ifdef OFMAP_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        hv.delete();
        hd.delete();
        mq.delete();
        for (int i = 0; i < MC - 1; i++) begin
            hv.push_back('0);
            hd.push_back('0);
        end
        m_frame = 0;
        m_fd    = 1'b0;
        m_ovf   = 1'b0;
        m_skew  = 1'b0;
    endtask

    // One clock edge of the model: lane c of the aligned row is the input
    // that column c produced MC-1-c cycles ago.
    task automatic model_step(input logic [MC-1:0] v, input ofmap_vec_t d, input logic rdy, input logic r);
        logic [MC-1:0] av;
        ofmap_vec_t    ad;
        if (r) begin
            model_reset();
            return;
        end
        hv.push_front(v);
        hd.push_front(d);
        for (int c = 0; c < MC; c++) begin
            av[c] = hv[MC-1-c][c];
            ad[c] = hd[MC-1-c][c];
        end
        void'(hv.pop_back());
        void'(hd.pop_back());
        m_fd = 1'b0;
        if (mq.size() > 0 && rdy) begin
            void'(mq.pop_front());
            m_frame++;
            if (m_frame == FL) begin
                m_frame = 0;
                m_fd    = 1'b1;
            end
        end
        if (av == '1) begin
            if (mq.size() < FD) mq.push_back(relu_vec(ad));
            else m_ovf = 1'b1;
        end else if (av != '0) begin
            m_skew = 1'b1;
        end
    endtask

    // Schedule one row: column c appears delay+c cycles from now; one column
    // may be moved a cycle early to create a skewed row.
    task automatic launch(input int delay, input ofmap_vec_t vals, input int early_col);
        for (int c = 0; c < MC; c++) begin
            int s;
            s = (cyc + delay + c - ((c == early_col) ? 1 : 0)) % RING;
            pv[s][c] = 1'b1;
            pd[s][c] = vals[c];
        end
    endtask

    // Apply this cycle's inputs, compare at the falling edge, advance model.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            int s;
            logic [CW+3:0] exp_st;
            s = cyc % RING;
            vin = pv[s];
            din = pd[s];
            pv[s] = '0;
            pd[s] = '0;
            #4;
            exp_st = {mq.size() > 0, CW'(mq.size()), m_fd, m_ovf, m_skew};
            check("status", {out_valid, fifo_count, frame_done, overflow_err, skew_err}, exp_st);
            if (mq.size() > 0) check("out_data", out_data, mq[0]);
            if (out_valid && out_ready) begin
                rx.push_back(ofmap_vec_t'(out_data));
                xfer_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (out_valid && first_valid < 0) first_valid = cyc;
            model_step(vin, din, out_ready, rst);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        for (int s = 0; s < RING; s++) begin
            pv[s] = '0;
            pd[s] = '0;
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        rx.delete();
        xfer_cyc.delete();
        fd_cyc.delete();
        first_valid = -1;
    endtask

    function automatic ofmap_vec_t mkvec(input int base, input int step);
        for (int c = 0; c < MC; c++) mkvec[c] = W'(base + step * c);
    endfunction

    lane_case_t lane_tab [5];

    initial begin
        int l0;
        lane_tab[0] = '{val: -5,            exp: relu_lane(-5)};
        lane_tab[1] = '{val: 5,             exp: 5};
        lane_tab[2] = '{val: 0,             exp: 0};
        lane_tab[3] = '{val: 32'h7fffffff,  exp: 32'h7fffffff};
        lane_tab[4] = '{val: 32'h80000000,  exp: relu_lane(32'h80000000)};

        for (int s = 0; s < RING; s++) begin
            pv[s] = '0;
            pd[s] = '0;
        end
        vin = '0;
        din = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state.
        check("rst_state", {out_valid, fifo_count, frame_done, overflow_err, skew_err}, '0);
        check("rst_data", out_data, '0);

        // Diagonal stream of four rows, lane c = c*100 + n.
        do_reset();
        clear_obs();
        out_ready = 1'b1;
        l0 = cyc + 1;
        for (int n = 0; n < 4; n++) launch(1 + n, mkvec(n, 100), -1);
        tick(30);
        check("diag_latency", first_valid, l0 + MC);
        check("diag_count", rx.size(), 4);
        for (int n = 0; n < 4 && n < rx.size(); n++) check("diag_vec", rx[n], mkvec(n, 100));
        check("diag_errs", {overflow_err, skew_err}, 2'b00);

        // Backpressure: eight rows fill, ninth overflows, drain keeps order.
        do_reset();
        clear_obs();
        out_ready = 1'b0;
        for (int n = 0; n < 9; n++) launch(1 + n, mkvec(1000 * n, 1), -1);
        tick(24);
        check("ovf_full_count", fifo_count, FD);
        check("ovf_not_yet", overflow_err, 1'b0);
        tick(6);
        check("ovf_set", overflow_err, 1'b1);
        check("ovf_count_held", fifo_count, FD);
        out_ready = 1'b1;
        tick(12);
        check("ovf_drain_count", rx.size(), FD);
        for (int n = 0; n < FD && n < rx.size(); n++) check("ovf_drain_order", rx[n][0], 1000 * n);

        // Full FIFO, read and write on the same edge.
        do_reset();
        clear_obs();
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) launch(1 + n, mkvec(1000 * n, 1), -1);
        tick(30);
        launch(1, mkvec(77000, 1), -1);
        tick(16);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("simul_count", fifo_count, FD);
        check("simul_ovf", overflow_err, 1'b0);
        out_ready = 1'b1;
        tick(12);
        check("simul_rx", rx.size(), 9);
        if (rx.size() == 9) check("simul_last", rx[8], mkvec(77000, 1));

        // Column 3 one cycle early: that row vanishes, neighbours survive.
        do_reset();
        clear_obs();
        out_ready = 1'b1;
        launch(1, mkvec(11, 2), -1);
        launch(20, mkvec(22, 2), 3);
        launch(40, mkvec(33, 2), -1);
        tick(60);
        check("skew_flag", skew_err, 1'b1);
        check("skew_rx", rx.size(), 2);
        if (rx.size() == 2) begin
            check("skew_first", rx[0], mkvec(11, 2));
            check("skew_last", rx[1], mkvec(33, 2));
        end

        // Frame boundary with FRAME_LEN=4.
        do_reset();
        clear_obs();
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) launch(1 + n, mkvec(n, 3), -1);
        tick(30);
        check("frame_pulses", fd_cyc.size(), 1);
        if (fd_cyc.size() >= 1 && xfer_cyc.size() >= 4) check("frame_when", fd_cyc[0], xfer_cyc[3] + 1);
        for (int n = 0; n < 2; n++) launch(1 + n, mkvec(n, 5), -1);
        tick(25);
        check("frame_restart", fd_cyc.size(), 2);

        // Reset with three rows buffered and one row mid-deskew.
        do_reset();
        clear_obs();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) launch(1 + n, mkvec(n, 7), -1);
        tick(22);
        check("rst_pre_count", fifo_count, 3);
        launch(1, mkvec(99, 7), -1);
        tick(8);
        do_reset();
        check("rst_mid_state", {out_valid, fifo_count, frame_done, overflow_err, skew_err}, '0);
        tick(25);
        check("rst_inflight", {out_valid, skew_err}, 2'b00);

        // Lane value table (signed extremes, optional rectification).
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ofmap_vec_t v;
            do_reset();
            clear_obs();
            for (int c = 0; c < MC; c++) v[c] = lane_tab[i].val;
            launch(1, v, -1);
            tick(20);
            check("lane_rx", rx.size(), 1);
            if (rx.size() == 1) begin
                check("lane_first", rx[0][0], lane_tab[i].exp);
                check("lane_last", rx[0][MC-1], lane_tab[i].exp);
            end
        end

        // Randomized rows, skew and backpressure against the model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                ofmap_vec_t v;
                for (int c = 0; c < MC; c++) v[c] = $urandom;
                launch(1, v, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, MC - 1)) : -1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (k == 250) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end
        out_ready = 1'b1;
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
